// File: rtl/snn_tick_scheduler.sv
// Tick sequencer and programming-port owner for snn_core.
// Optional per-window spike rate output: define SCHED_RATE_WINDOW_EN.
module snn_tick_scheduler #(
  parameter int NUM_INPUTS   = 256,
  parameter int PERIOD_W     = 16,
  parameter int CNT_W        = 16,
  parameter int WINDOW_TICKS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run_en,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                host_wr_valid,
  output logic                host_wr_ready,
  input  logic [7:0]          host_wr_addr,
  input  logic [7:0]          host_wr_data,
  output logic                core_program_mode,
  output logic [7:0]          core_prog_addr,
  output logic [7:0]          core_prog_data,
  output logic                core_prog_wr_en,
  output logic                core_start_tick,
  input  logic                core_busy,
  input  logic                core_fire,
  output logic [CNT_W-1:0]    spike_count,
  output logic                tick_done,
  output logic                overrun,
  output logic                err_no_ack,
  output logic [CNT_W-1:0]    rate_out,
  output logic                rate_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_PROG_WR, S_PROG_GUARD, S_START, S_WAIT_BUSY, S_RUN
  } state_t;

  // WAIT_BUSY cycles after the start pulse before giving up: S+1..S+3
  localparam logic [1:0] ACK_WAIT = 2'd2;

  state_t              state;
  logic [PERIOD_W-1:0] period_cnt;
  logic                tick_pending;
  logic [1:0]          ack_timer;
  logic                expire;
  logic                take_tick;
  logic                wr_fire;
  logic [CNT_W-1:0]    count_next;
  logic                unused_params;

  assign unused_params = (NUM_INPUTS > 0) ^ (WINDOW_TICKS > 0);

  assign expire        = run_en && (period_cnt == cfg_period);
  assign take_tick     = (state == S_IDLE) && tick_pending;
  assign host_wr_ready = !rst && (((state == S_IDLE) && !tick_pending) ||
                                  (state == S_PROG_GUARD));
  assign wr_fire       = host_wr_valid && host_wr_ready;
  assign count_next    = (core_fire && (spike_count != '1)) ?
                         spike_count + CNT_W'(1) : spike_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt   <= '0;
      tick_pending <= 1'b0;
      overrun      <= 1'b0;
    end else if (!run_en) begin
      period_cnt   <= '0;
      tick_pending <= 1'b0;
    end else begin
      period_cnt <= expire ? '0 : period_cnt + PERIOD_W'(1);
      // A pending tick being taken this very cycle is not a miss.
      if (expire) begin
        if (tick_pending && !take_tick) overrun <= 1'b1;
        tick_pending <= 1'b1;
      end else if (take_tick) begin
        tick_pending <= 1'b0;
      end
    end
  end

`ifdef SCHED_RATE_WINDOW_EN
  localparam int WIN_W = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_TICKS - 1);
  logic [WIN_W-1:0] win_cnt;
`else
  assign rate_out   = '0;
  assign rate_valid = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      core_program_mode <= 1'b0;
      core_prog_addr    <= '0;
      core_prog_data    <= '0;
      core_prog_wr_en   <= 1'b0;
      core_start_tick   <= 1'b0;
      spike_count       <= '0;
      tick_done         <= 1'b0;
      err_no_ack        <= 1'b0;
      ack_timer         <= '0;
`ifdef SCHED_RATE_WINDOW_EN
      win_cnt           <= '0;
      rate_out          <= '0;
      rate_valid        <= 1'b0;
`endif
    end else begin
      core_start_tick <= 1'b0;
      core_prog_wr_en <= 1'b0;
      tick_done       <= 1'b0;
`ifdef SCHED_RATE_WINDOW_EN
      rate_valid      <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (tick_pending) begin
            state           <= S_START;
            core_start_tick <= 1'b1;
          end else if (wr_fire) begin
            state             <= S_PROG_WR;
            core_program_mode <= 1'b1;
            core_prog_wr_en   <= 1'b1;
            core_prog_addr    <= host_wr_addr;
            core_prog_data    <= host_wr_data;
          end
        end
        S_PROG_WR: state <= S_PROG_GUARD;
        S_PROG_GUARD: begin
          if (wr_fire) begin
            state           <= S_PROG_WR;
            core_prog_wr_en <= 1'b1;
            core_prog_addr  <= host_wr_addr;
            core_prog_data  <= host_wr_data;
          end else begin
            state             <= S_IDLE;
            core_program_mode <= 1'b0;
          end
        end
        S_START: begin
          state     <= S_WAIT_BUSY;
          ack_timer <= ACK_WAIT;
        end
        S_WAIT_BUSY: begin
          if (core_busy) begin
            state <= S_RUN;
          end else if (ack_timer == 2'd0) begin
            err_no_ack <= 1'b1;
            state      <= S_IDLE;
          end else begin
            ack_timer <= ack_timer - 2'd1;
          end
        end
        S_RUN: begin
          if (!core_busy) begin
            tick_done <= 1'b1;
            state     <= S_IDLE;
`ifdef SCHED_RATE_WINDOW_EN
            if (win_cnt == WIN_LAST) begin
              win_cnt     <= '0;
              rate_out    <= count_next;
              rate_valid  <= 1'b1;
              spike_count <= '0;
            end else begin
              win_cnt     <= win_cnt + WIN_W'(1);
              spike_count <= count_next;
            end
`else
            spike_count <= count_next;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_tick_scheduler.sv
// Scoreboard bench for snn_tick_scheduler with a behavioural snn_core stand-in.
module tb_snn_tick_scheduler;

`ifdef SCHED_RATE_WINDOW_EN
  localparam int WT = 4;
`else
  localparam int WT = 64;
`endif
  localparam int CW  = 16;
  localparam int SAT = (1 << CW) - 1;
  localparam int BUSY_LEN = 258;

  logic clk = 1'b0;
  logic rst, run_en;
  logic [15:0] cfg_period;
  logic host_wr_valid, host_wr_ready;
  logic [7:0] host_wr_addr, host_wr_data;
  logic core_program_mode, core_prog_wr_en, core_start_tick;
  logic [7:0] core_prog_addr, core_prog_data;
  logic core_busy, core_fire;
  logic [CW-1:0] spike_count, rate_out;
  logic tick_done, overrun, err_no_ack, rate_valid;

  snn_tick_scheduler #(.NUM_INPUTS(256), .PERIOD_W(16), .CNT_W(CW), .WINDOW_TICKS(WT)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .cfg_period(cfg_period),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .core_program_mode(core_program_mode), .core_prog_addr(core_prog_addr),
    .core_prog_data(core_prog_data), .core_prog_wr_en(core_prog_wr_en),
    .core_start_tick(core_start_tick), .core_busy(core_busy), .core_fire(core_fire),
    .spike_count(spike_count), .tick_done(tick_done), .overrun(overrun),
    .err_no_ack(err_no_ack), .rate_out(rate_out), .rate_valid(rate_valid)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard queues and reference model ----------------
  logic [15:0] wr_q[$];
  int tick_q[$];
  int rate_q[$];

  int core_mode = 0;   // 0: normal core, 1: core never acknowledges
  int fire_mode = 0;   // 0: fire on every second tick, 1: random, 2: every tick
  int busy_cnt = 0;
  bit fire_r = 1'b0;
  int tick_idx = 0;
  int ref_spk = 0;
  int ref_win = 0;
  bit f_dec;

  assign core_busy = (busy_cnt != 0);
  assign core_fire = fire_r;

  always @(posedge clk) begin
    if (rst) begin
      busy_cnt <= 0;
      fire_r   <= 1'b0;
      tick_idx = 0;
      ref_spk  = 0;
      ref_win  = 0;
      tick_q.delete();
      rate_q.delete();
    end else begin
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      if (core_start_tick && core_mode == 0) begin
        busy_cnt <= BUSY_LEN;
        if (fire_mode == 0)      f_dec = ((tick_idx % 2) == 1);
        else if (fire_mode == 2) f_dec = 1'b1;
        else                     f_dec = ($urandom_range(0, 1) == 1);
        fire_r <= f_dec;
        tick_idx++;
        if (f_dec && ref_spk < SAT) ref_spk++;
`ifdef SCHED_RATE_WINDOW_EN
        ref_win++;
        if (ref_win == WT) begin
          rate_q.push_back(ref_spk);
          ref_spk = 0;
          ref_win = 0;
        end
`endif
        tick_q.push_back(ref_spk);
      end
    end
  end

  // ---------------- monitor ----------------
  int n_start = 0, n_done = 0, n_rate = 0, mode_cycles = 0, rate_bad = 0;
  int last_wr_cyc = 0, prev_wr_cyc = 0, last_start_cyc = 0;
  bit have_prev = 1'b0;
  bit spacing_check = 1'b0;
  int exp_gap = 0;
  logic [15:0] exp_w;
  int exp_i;

  always @(negedge clk) begin
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      if (core_program_mode) mode_cycles++;
      if (core_prog_wr_en) begin
        chk("wr_mode", core_program_mode, 1);
        chk("wr_expected", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          exp_w = wr_q.pop_front();
          chk("wr_addr_data", {core_prog_addr, core_prog_data}, exp_w);
        end
        prev_wr_cyc = last_wr_cyc;
        last_wr_cyc = cyc;
      end
      if (core_start_tick) begin
        chk("start_mode_low", core_program_mode, 0);
        chk("start_busy_low", core_busy, 0);
        if (spacing_check && have_prev) chk("start_spacing", cyc - last_start_cyc, exp_gap);
        last_start_cyc = cyc;
        have_prev = 1'b1;
        n_start++;
      end
      if (tick_done) begin
        chk("tick_expected", tick_q.size() != 0, 1);
        if (tick_q.size() != 0) begin
          exp_i = tick_q.pop_front();
          chk("tick_spike_count", spike_count, exp_i);
        end
        n_done++;
      end
`ifdef SCHED_RATE_WINDOW_EN
      if (rate_valid) begin
        chk("rate_expected", rate_q.size() != 0, 1);
        if (rate_q.size() != 0) begin
          exp_i = rate_q.pop_front();
          chk("rate_out", rate_out, exp_i);
        end
        chk("rate_clears_count", spike_count, 0);
        chk("rate_with_tick_done", tick_done, 1);
        n_rate++;
      end
`else
      if (rate_valid || rate_out != '0) rate_bad++;
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    bit acc;
    host_wr_addr  = a;
    host_wr_data  = d;
    host_wr_valid = 1'b1;
    wr_q.push_back({a, d});
    acc = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      #1;
      if (host_wr_ready) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    chk("wr_accept_timeout", acc, 1);
    @(negedge clk);
    host_wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk("tick_q_drained", tick_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    rst = 1'b1;
    run_en = 1'b0;
    host_wr_valid = 1'b0;
    core_mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1);
  end

  int d0, m0, s0, sc, ec, early;
  bit seen, acc;

  initial begin
    // Reset with live inputs
    rst = 1'b1; run_en = 1'b1; cfg_period = 16'd0;
    host_wr_valid = 1'b1; host_wr_addr = 8'h11; host_wr_data = 8'h22;
    @(posedge clk); @(negedge clk);
    chk("rst_wr_ready", host_wr_ready, 0);
    chk("rst_prog_mode", core_program_mode, 0);
    chk("rst_prog_addr", core_prog_addr, 0);
    chk("rst_prog_data", core_prog_data, 0);
    chk("rst_wr_en", core_prog_wr_en, 0);
    chk("rst_start", core_start_tick, 0);
    chk("rst_spike_count", spike_count, 0);
    chk("rst_tick_done", tick_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_err_no_ack", err_no_ack, 0);
    chk("rst_rate_out", rate_out, 0);
    chk("rst_rate_valid", rate_valid, 0);
    @(posedge clk); @(negedge clk);
    chk("rst2_start", core_start_tick, 0);
    chk("rst2_wr_en", core_prog_wr_en, 0);
    chk("rst2_wr_ready", host_wr_ready, 0);
    rst = 1'b0; run_en = 1'b0; host_wr_valid = 1'b0;

    // Back-to-back host writes while idle
    repeat (2) @(negedge clk);
    m0 = mode_cycles;
    do_write(8'h05, 8'hFD);
    do_write(8'h06, 8'h64);
    repeat (3) @(negedge clk);
    chk("b2b_wr_gap", last_wr_cyc - prev_wr_cyc, 2);
    chk("b2b_mode_cycles", mode_cycles - m0, 4);
    chk("b2b_mode_dropped", core_program_mode, 0);
    chk("prog_hold", {core_prog_addr, core_prog_data}, 16'h0664);

    // Periodic ticks, period 300, fire on every second tick
    do_reset();
    fire_mode = 0; cfg_period = 16'd299; exp_gap = 300; spacing_check = 1'b1;
    d0 = n_done; s0 = n_start;
    run_en = 1'b1;
    for (int n = 0; n < 3600; n++) begin
      @(negedge clk); #1;
      if (n_done - d0 >= 10) break;
    end
    spacing_check = 1'b0;
    run_en = 1'b0;
    chk("p300_ticks_done", n_done - d0, 10);
    chk("p300_starts", n_start - s0, 10);
`ifdef SCHED_RATE_WINDOW_EN
    chk("p300_spike_count", spike_count, 1);
`else
    chk("p300_spike_count", spike_count, 5);
`endif
    chk("p300_overrun", overrun, 0);
    chk("p300_err", err_no_ack, 0);

    // Period shorter than a tick: overrun
    do_reset();
    fire_mode = 1; cfg_period = 16'd99;
    run_en = 1'b1;
    repeat (400) @(negedge clk);
    chk("overrun_set", overrun, 1);
    repeat (800) @(negedge clk);
    chk("overrun_sticky", overrun, 1);
    run_en = 1'b0;
    repeat (300) @(negedge clk);
    chk("overrun_sticky_off", overrun, 1);

    // Write requested in the cycle a tick becomes pending: tick wins
    do_reset();
    fire_mode = 2; cfg_period = 16'd299; run_en = 1'b1;
    d0 = n_done;
    repeat (300) @(negedge clk);
    host_wr_addr = 8'hA5; host_wr_data = 8'h3C; host_wr_valid = 1'b1;
    wr_q.push_back(16'hA53C);
    #1;
    chk("ready_low_pending", host_wr_ready, 0);
    early = 0; seen = 1'b0; acc = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (n_done != d0) seen = 1'b1;
      if (host_wr_ready) begin
        if (!seen) early++;
        acc = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    chk("pend_wr_accepted", acc, 1);
    chk("pend_ready_early", early, 0);
    chk("pend_tick_first", seen, 1);
    @(negedge clk);
    host_wr_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pend_wr_after_start", last_wr_cyc > last_start_cyc, 1);
    run_en = 1'b0;
    repeat (2) @(negedge clk);

    // Core never acknowledges
    do_reset();
    core_mode = 1; cfg_period = 16'd299; run_en = 1'b1;
    d0 = n_done; sc = -1; ec = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); #1;
      if (core_start_tick) begin sc = cyc; break; end
    end
    chk("noack_start_seen", sc >= 0, 1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (err_no_ack) begin ec = cyc; break; end
    end
    chk("noack_delay", ec - sc, 4);
    chk("noack_idle_ready", host_wr_ready, 1);
    run_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("noack_no_tick_done", n_done - d0, 0);
    chk("noack_sticky", err_no_ack, 1);
    core_mode = 0;

`ifdef SCHED_RATE_WINDOW_EN
    // Rate window of 4 ticks, fire every tick
    do_reset();
    fire_mode = 2; cfg_period = 16'd279; run_en = 1'b1;
    d0 = n_done; s0 = n_rate;
    for (int n = 0; n < 1800; n++) begin
      @(negedge clk); #1;
      if (n_rate != s0) break;
    end
    chk("window_pulse", n_rate - s0, 1);
    chk("window_ticks", n_done - d0, 4);
    run_en = 1'b0;
    repeat (300) @(negedge clk);
`endif

    // Randomized writes interleaved with ticks
    do_reset();
    fire_mode = 1; cfg_period = 16'(280 + $urandom_range(0, 60)); run_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      do_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    run_en = 1'b0;
    repeat (400) @(negedge clk);
    chk("rand_overrun", overrun, 0);
    chk("rand_err", err_no_ack, 0);
    chk("rand_wr_q_empty", wr_q.size(), 0);
    chk("rand_tick_q_empty", tick_q.size(), 0);
    chk("rate_q_empty", rate_q.size(), 0);
`ifndef SCHED_RATE_WINDOW_EN
    chk("rate_disabled", rate_bad, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/snn_tick_scheduler.md
Name: snn_tick_scheduler

Overview:
Sequencer in front of snn_core. Issues start_tick at a programmable period and owns the core's programming port. Lets a host stream synaptic weight writes only while the core is idle, and never during a tick. Counts output spikes per tick and flags missed ticks (overrun) and unacknowledged ticks.

Parameters:
NUM_INPUTS, 256, synapse count of the sequenced core (informational; min overrun-free period = NUM_INPUTS+4)
PERIOD_W, 16, width of tick period counter / cfg_period
CNT_W, 16, width of spike_count (saturating)
WINDOW_TICKS, 64, ticks per rate window (used only with SCHED_RATE_WINDOW_EN)

Ports:
clk  in  1  single clock
rst  in  1  reset; synchronous, active-high
run_en  in  1  enables periodic tick generation
cfg_period  in  PERIOD_W  tick period in cycles minus 1
host_wr_valid  in  1  host weight-write request
host_wr_ready  out  1  scheduler accepts write this cycle
host_wr_addr  in  8  synapse address
host_wr_data  in  8  signed weight
core_program_mode  out  1  to core program_mode
core_prog_addr  out  8  to core prog_addr
core_prog_data  out  8  to core prog_data (signed)
core_prog_wr_en  out  1  to core prog_wr_en
core_start_tick  out  1  one-cycle start pulse to core
core_busy  in  1  from core busy
core_fire  in  1  from core neuron_fire
spike_count  out  CNT_W  spikes counted (saturating)
tick_done  out  1  one-cycle pulse per completed tick
overrun  out  1  sticky: period expired while a tick was still pending
err_no_ack  out  1  sticky: core_busy never rose after start_tick
rate_out  out  CNT_W  spikes in last completed window
rate_valid  out  1  one-cycle pulse when rate_out updates

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0, FSM=IDLE, period counter 0, tick_pending 0, sticky flags cleared. Reset mid-write or mid-tick abandons the operation; core_program_mode drops the next cycle.
- Period counter: runs while run_en=1 and wraps at cfg_period (expiry every cfg_period+1 cycles). On expiry, set tick_pending; if tick_pending is already 1, set overrun and drop the tick. cfg_period=0 expires every cycle.
- run_en=0: counter and tick_pending clear; an in-flight tick still completes.
- FSM states: IDLE, PROG_WR, PROG_GUARD, START, WAIT_BUSY, RUN.
- IDLE priority is tick_pending over host write. host_wr_ready=1 only in IDLE with tick_pending=0, or in PROG_GUARD.
- IDLE, tick_pending=1 -> START. Pulse core_start_tick for 1 cycle, clear tick_pending -> WAIT_BUSY.
- IDLE, tick_pending=0, valid&ready -> PROG_WR. Register addr/data, drive program_mode=1 and prog_wr_en=1 for exactly 1 cycle -> PROG_GUARD.
- PROG_GUARD: program_mode=1, wr_en=0. valid&ready -> PROG_WR (back-to-back, program_mode held). Otherwise -> IDLE, program_mode=0.
- A tick expiring during PROG_* is held pending and serviced from IDLE after the guard cycle.
- WAIT_BUSY: core_busy=1 -> RUN. If core_busy is not seen within 4 cycles of the start pulse, set err_no_ack -> IDLE with no tick_done.
- RUN: wait for core_busy=0. In that same cycle sample core_fire; if 1, spike_count += 1 (saturate at all-ones). Pulse tick_done -> IDLE.
- core_program_mode is never 1 in START/WAIT_BUSY/RUN.
- core_prog_* hold their last values when wr_en=0.

Optional Feature:
SCHED_RATE_WINDOW_EN.
- Defined: count completed ticks. On the WINDOW_TICKS-th tick_done, copy the updated spike_count (including that tick's spike) to rate_out, pulse rate_valid, and clear spike_count the same cycle.
- Undefined: rate_out=0, rate_valid=0; spike_count is free-running saturating.

Test Plan:
1. rst=1 for 2 cycles with host_wr_valid=1 and run_en=1 -> every output 0, no start pulse and no write during reset.
2. run_en=0; write addr 0x05 data -3, then addr 0x06 data 100 back-to-back -> core_prog_wr_en high 2 non-adjacent cycles carrying (0x05,0xFD) then (0x06,0x64); program_mode continuous from first PROG_WR to one cycle after last.
3. cfg_period=299, run_en=1, core model busy for 258 cycles, fire=1 on every second tick -> start pulses 300 cycles apart, tick_done each tick, spike_count=5 after 10 ticks, overrun=0.
4. cfg_period=99 with 258-cycle busy -> overrun=1 and stays 1; start pulses never overlap busy.
5. Host write pending when a tick expires in IDLE -> START taken first, host_wr_ready=0 until tick_done; write then completes.
6. Core model never raises busy -> err_no_ack=1 exactly 4 cycles after start pulse, FSM back in IDLE. With SCHED_RATE_WINDOW_EN, WINDOW_TICKS=4, fire every tick -> rate_out=4, rate_valid pulse on 4th tick_done, spike_count=0.
